// File: rtl/interrupt_timer_pkg.sv
// Shared definitions for the 68000 bus interrupt timer: register map,
// control/status bit positions, bus FSM encoding and IACK address match.
package interrupt_timer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 24;

  // Register select is the word index ADDR_IN[3:1]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_RELOAD = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IE     = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned STATUS_PEND = 0;

  // Interrupt-acknowledge cycles drive A23..A4 all high
  localparam logic [19:0] IACK_ADDR_HI = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic oneshot;
    logic ie;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/interrupt_timer_tick_prescaler.sv
// Divides the CPU clock by PRESCALE; tick is high for the one cycle in
// which the counter sits at its last value while enabled.
module interrupt_timer_tick_prescaler #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/interrupt_timer.sv
// Memory-mapped 16-bit periodic/one-shot timer with an autovectored
// interrupt on the 68000 bus; acknowledges its own register and IACK cycles.
module interrupt_timer
  import interrupt_timer_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'hFF0000,
  parameter logic [2:0]  IRQ_LEVEL = 3'd6,
  parameter int unsigned PRESCALE  = 8
) (
  input  logic              CPUCLK_IN,
  input  logic              RESET_IN,
  input  logic              AS_IN,
  input  logic              WR_IN,
  input  logic              UDS_IN,
  input  logic              LDS_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  output logic              DTACK,
  output logic              AVEC,
  output logic [2:0]        IPL
);

  bus_state_e        state, state_d;
  logic              iack_q, iack_d;
  logic              dtack_d, avec_d, oe_d;
  logic [DATA_W-1:0] data_d, rd_mux;

  ctrl_t             ctrl;
  logic [DATA_W-1:0] reload_q, count_q;
  logic              pend_q;

  logic              hit_c, iack_c, wr_c, iack_commit_c;
  logic [2:0]        reg_sel;
  logic              ctrl_wr_lo, en_rise, tick, tick_eff, wrap, pend_clr;
  logic              unused_addr0;

  assign unused_addr0 = ADDR_IN[0];
  assign reg_sel      = ADDR_IN[3:1];

  assign hit_c  = AS_IN && (UDS_IN || LDS_IN) && (ADDR_IN[23:4] == BASE_ADDR[23:4]);
  assign iack_c = AS_IN && !WR_IN && (ADDR_IN[23:4] == IACK_ADDR_HI)
                  && (ADDR_IN[3:1] == IRQ_LEVEL);

  assign wr_c          = (state == ST_IDLE) && hit_c && !iack_c && WR_IN;
  assign iack_commit_c = (state == ST_IDLE) && iack_c;

  // Register read mux; unmapped offsets read zero
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_CTRL:   rd_mux = DATA_W'(ctrl);
      REG_RELOAD: rd_mux = reload_q;
      REG_COUNT:  rd_mux = count_q;
      REG_STATUS: rd_mux[STATUS_PEND] = pend_q;
      default:    rd_mux = '0;
    endcase
  end

  // Bus FSM next state; outputs lag the state by one edge
  always_comb begin
    state_d = state;
    iack_d  = iack_q;
    dtack_d = 1'b0;
    avec_d  = 1'b0;
    oe_d    = 1'b0;
    data_d  = DATA_OUT;
    case (state)
      ST_IDLE: begin
        if (iack_c) begin
          state_d = ST_ACK;
          iack_d  = 1'b1;
          data_d  = '0;
        end else if (hit_c) begin
          state_d = ST_ACK;
          iack_d  = 1'b0;
          data_d  = WR_IN ? '0 : rd_mux;
        end
      end
      ST_ACK: begin
        if (!AS_IN) begin
          state_d = ST_WAIT;
        end else begin
          dtack_d = !iack_q;
          avec_d  = iack_q;
          oe_d    = !iack_q && !WR_IN;
        end
      end
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state    <= ST_IDLE;
      iack_q   <= 1'b0;
      DTACK    <= 1'b0;
      AVEC     <= 1'b0;
      DATA_OE  <= 1'b0;
      DATA_OUT <= '0;
    end else begin
      state    <= state_d;
      iack_q   <= iack_d;
      DTACK    <= dtack_d;
      AVEC     <= avec_d;
      DATA_OE  <= oe_d;
      DATA_OUT <= data_d;
    end
  end

  assign ctrl_wr_lo = wr_c && (reg_sel == REG_CTRL) && LDS_IN;
  assign en_rise    = ctrl_wr_lo && DATA_IN[CTRL_EN] && !ctrl.en;
  // A CTRL write that stops the timer swallows a coincident tick
  assign tick_eff   = tick && !(ctrl_wr_lo && !DATA_IN[CTRL_EN]);
  assign wrap       = tick_eff && (count_q == '0);
  assign pend_clr   = (wr_c && (reg_sel == REG_STATUS) && LDS_IN && DATA_IN[STATUS_PEND])
                      || iack_commit_c;

  interrupt_timer_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (CPUCLK_IN),
    .rst    (RESET_IN),
    .enable (ctrl.en),
    .clear  (en_rise),
    .tick   (tick)
  );

  // Timer registers; a tick setting PEND outranks any clear on the same edge
  always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      ctrl     <= '0;
      reload_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      IPL      <= 3'd0;
    end else begin
      if (ctrl_wr_lo) begin
        ctrl <= ctrl_t'(DATA_IN[$bits(ctrl_t)-1:0]);
      end else if (wrap && ctrl.oneshot) begin
        ctrl.en <= 1'b0;
      end

      if (wr_c && (reg_sel == REG_RELOAD)) begin
        if (UDS_IN) reload_q[15:8] <= DATA_IN[15:8];
        if (LDS_IN) reload_q[7:0]  <= DATA_IN[7:0];
      end

      if (en_rise) begin
        count_q <= reload_q;
      end else if (tick_eff) begin
        count_q <= wrap ? reload_q : count_q - DATA_W'(1);
      end

      if (wrap) begin
        pend_q <= 1'b1;
      end else if (pend_clr) begin
        pend_q <= 1'b0;
      end

      IPL <= (pend_q && ctrl.ie) ? IRQ_LEVEL : 3'd0;
    end
  end

endmodule

// File: tb/tb_interrupt_timer.sv
// Directed bench for interrupt_timer: register access, periodic and one-shot
// timing, IACK handling, byte lanes, set/clear races and mid-cycle reset.
module tb_interrupt_timer;

  localparam logic [23:0] BASE = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst, as_i, wr, uds, lds;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic [15:0] data_out;
  logic        data_oe, dtack, avec;
  logic [2:0]  ipl;

  int          cyc = 0;
  int          nchecks = 0;
  int          nerrors = 0;
  int          ipl_rises = 0;
  int          last_rise_cyc = -1;
  logic [2:0]  ipl_prev = 3'd0;

  int          b_commit, b_lat;
  logic [15:0] b_rd;
  logic        b_dt, b_av, b_oe;
  logic [2:0]  b_ipl;

  interrupt_timer #(
    .BASE_ADDR (BASE),
    .IRQ_LEVEL (3'd6),
    .PRESCALE  (8)
  ) dut (
    .CPUCLK_IN (clk),
    .RESET_IN  (rst),
    .AS_IN     (as_i),
    .WR_IN     (wr),
    .UDS_IN    (uds),
    .LDS_IN    (lds),
    .ADDR_IN   (addr),
    .DATA_IN   (wdata),
    .DATA_OUT  (data_out),
    .DATA_OE   (data_oe),
    .DTACK     (dtack),
    .AVEC      (avec),
    .IPL       (ipl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Records when IPL leaves zero (cycle number = posedges seen so far)
  always @(negedge clk) begin
    if (ipl != 3'd0 && ipl_prev == 3'd0) begin
      ipl_rises++;
      last_rise_cyc = cyc;
    end
    ipl_prev = ipl;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Caller must be at a negedge; returns at a negedge with the FSM idle
  task automatic bus_cycle(input logic w, input logic [23:0] a, input logic [15:0] d,
                           input logic u, input logic l);
    as_i = 1'b1; wr = w; addr = a; wdata = d; uds = u; lds = l;
    b_commit = cyc + 1;
    b_lat = 99; b_rd = '0; b_dt = 1'b0; b_av = 1'b0; b_oe = 1'b0; b_ipl = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (dtack || avec) begin
        b_lat = k; b_rd = data_out; b_dt = dtack; b_av = avec; b_oe = data_oe; b_ipl = ipl;
        break;
      end
    end
    as_i = 1'b0; wr = 1'b0; uds = 1'b0; lds = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [23:0] a, input logic [15:0] d, input logic u, input logic l);
    bus_cycle(1'b1, a, d, u, l);
  endtask

  task automatic rd_reg(input logic [23:0] a);
    bus_cycle(1'b0, a, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic wait_until(input int target);
    while (cyc + 1 < target) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; as_i = 1'b0; wr = 1'b0; uds = 1'b0; lds = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    nchecks++;
    if ({dtack, avec, data_oe} !== 3'b000) begin
      nerrors++; $display("FAIL reset_bus_outs: got %b expected 000", {dtack, avec, data_oe});
    end
    nchecks++;
    if (ipl !== 3'd0) begin nerrors++; $display("FAIL reset_ipl: got %0d expected 0", ipl); end
    nchecks++;
    if (data_out !== 16'h0000) begin
      nerrors++; $display("FAIL reset_data_out: got %h expected 0000", data_out);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_reg(BASE + 24'(2 * i));
      nchecks++;
      if (b_lat !== 2 || b_dt !== 1'b1 || b_oe !== 1'b1 || b_av !== 1'b0) begin
        nerrors++;
        $display("FAIL reset_read_ack[%0d]: lat %0d dtack %b oe %b avec %b expected 2 1 1 0",
                 i, b_lat, b_dt, b_oe, b_av);
      end
      nchecks++;
      if (b_rd !== 16'h0000) begin
        nerrors++; $display("FAIL reset_read_data[%0d]: got %h expected 0000", i, b_rd);
      end
    end
  endtask

  task automatic test_periodic;
    int c, r0;
    wr_reg(BASE + 24'd2, 16'h0003, 1'b1, 1'b1);
    r0 = ipl_rises;
    wr_reg(BASE, 16'h0003, 1'b1, 1'b1);
    c = b_commit;
    for (int i = 0; i < 4; i++) begin
      wait_until(c + 5 + 8 * i);
      rd_reg(BASE + 24'd4);
      nchecks++;
      if (b_rd !== 16'(3 - i)) begin
        nerrors++; $display("FAIL periodic_count[%0d]: got %0d expected %0d", i, b_rd, 3 - i);
      end
    end
    wait_until(c + 41);
    nchecks++;
    if (ipl_rises - r0 !== 1 || last_rise_cyc !== c + 33) begin
      nerrors++;
      $display("FAIL periodic_irq_time: rises %0d at cycle %0d expected 1 at %0d",
               ipl_rises - r0, last_rise_cyc, c + 33);
    end
    nchecks++;
    if (ipl !== 3'd6) begin nerrors++; $display("FAIL periodic_ipl: got %0d expected 6", ipl); end
    rd_reg(BASE + 24'd6);
    nchecks++;
    if (b_rd !== 16'h0001) begin
      nerrors++; $display("FAIL periodic_status: got %h expected 0001", b_rd);
    end
  endtask

  task automatic test_iack;
    bus_cycle(1'b0, 24'hFFFFFD, 16'h0000, 1'b0, 1'b1);
    nchecks++;
    if (b_lat !== 2 || b_av !== 1'b1 || b_dt !== 1'b0 || b_oe !== 1'b0) begin
      nerrors++;
      $display("FAIL iack_ack: lat %0d avec %b dtack %b oe %b expected 2 1 0 0",
               b_lat, b_av, b_dt, b_oe);
    end
    nchecks++;
    if (b_ipl !== 3'd0) begin nerrors++; $display("FAIL iack_ipl: got %0d expected 0", b_ipl); end
    wr_reg(BASE, 16'h0000, 1'b1, 1'b1);
    rd_reg(BASE + 24'd6);
    nchecks++;
    if (b_rd !== 16'h0000) begin
      nerrors++; $display("FAIL iack_pend_cleared: got %h expected 0000", b_rd);
    end
    bus_cycle(1'b0, 24'hFFFFFB, 16'h0000, 1'b0, 1'b1);
    nchecks++;
    if (b_lat !== 99) begin
      nerrors++; $display("FAIL iack_wrong_level: acked after %0d cycles expected no ack", b_lat);
    end
  endtask

  task automatic test_oneshot;
    int c, r0;
    wr_reg(BASE + 24'd2, 16'h0000, 1'b1, 1'b1);
    r0 = ipl_rises;
    wr_reg(BASE, 16'h0007, 1'b1, 1'b1);
    c = b_commit;
    wait_until(c + 40);
    nchecks++;
    if (ipl_rises - r0 !== 1 || last_rise_cyc !== c + 9) begin
      nerrors++;
      $display("FAIL oneshot_irq: rises %0d at cycle %0d expected 1 at %0d",
               ipl_rises - r0, last_rise_cyc, c + 9);
    end
    rd_reg(BASE);
    nchecks++;
    if (b_rd !== 16'h0006) begin
      nerrors++; $display("FAIL oneshot_ctrl: got %h expected 0006", b_rd);
    end
    rd_reg(BASE + 24'd4);
    nchecks++;
    if (b_rd !== 16'h0000) begin
      nerrors++; $display("FAIL oneshot_count: got %h expected 0000", b_rd);
    end
    wr_reg(BASE + 24'd6, 16'h0001, 1'b0, 1'b1);
    nchecks++;
    if (ipl !== 3'd0) begin
      nerrors++; $display("FAIL oneshot_status_clear: ipl %0d expected 0", ipl);
    end
  endtask

  task automatic test_byte_lanes;
    wr_reg(BASE + 24'd2, 16'hAB00, 1'b1, 1'b1);
    wr_reg(BASE + 24'd2, 16'hCD12, 1'b0, 1'b1);
    rd_reg(BASE + 24'd2);
    nchecks++;
    if (b_rd !== 16'hAB12) begin
      nerrors++; $display("FAIL byte_lds: got %h expected ab12", b_rd);
    end
    wr_reg(BASE + 24'd2, 16'h5634, 1'b1, 1'b0);
    rd_reg(BASE + 24'd2);
    nchecks++;
    if (b_rd !== 16'h5612) begin
      nerrors++; $display("FAIL byte_uds: got %h expected 5612", b_rd);
    end
    wr_reg(BASE + 24'd4, 16'hFFFF, 1'b1, 1'b1);
    nchecks++;
    if (b_lat !== 2 || b_dt !== 1'b1 || b_oe !== 1'b0) begin
      nerrors++;
      $display("FAIL count_write_ack: lat %0d dtack %b oe %b expected 2 1 0", b_lat, b_dt, b_oe);
    end
    rd_reg(BASE + 24'd4);
    nchecks++;
    if (b_rd !== 16'h0000) begin
      nerrors++; $display("FAIL count_readonly: got %h expected 0000", b_rd);
    end
    wr_reg(BASE + 24'd8, 16'hFFFF, 1'b1, 1'b1);
    rd_reg(BASE + 24'd8);
    nchecks++;
    if (b_rd !== 16'h0000) begin
      nerrors++; $display("FAIL unmapped_read: got %h expected 0000", b_rd);
    end
  endtask

  task automatic test_status_race;
    int c;
    wr_reg(BASE + 24'd2, 16'h0000, 1'b1, 1'b1);
    wr_reg(BASE, 16'h0003, 1'b1, 1'b1);
    c = b_commit;
    wait_until(c + 12);
    wr_reg(BASE + 24'd6, 16'h0001, 1'b0, 1'b1);
    nchecks++;
    if (b_commit !== c + 12 || b_ipl !== 3'd0) begin
      nerrors++;
      $display("FAIL race_plain_clear: commit %0d ipl %0d expected %0d 0", b_commit, b_ipl, c + 12);
    end
    wait_until(c + 16);
    wr_reg(BASE + 24'd6, 16'h0001, 1'b0, 1'b1);
    nchecks++;
    if (b_commit !== c + 16 || b_ipl !== 3'd6) begin
      nerrors++;
      $display("FAIL race_tick_beats_clear: commit %0d ipl %0d expected %0d 6",
               b_commit, b_ipl, c + 16);
    end
    wr_reg(BASE, 16'h0000, 1'b1, 1'b1);
    wr_reg(BASE + 24'd6, 16'h0001, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midcycle;
    wr_reg(BASE + 24'd2, 16'h1234, 1'b1, 1'b1);
    as_i = 1'b1; wr = 1'b0; addr = BASE; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nchecks++;
    if (dtack !== 1'b1) begin nerrors++; $display("FAIL midreset_pre: dtack %b expected 1", dtack); end
    #2 rst = 1'b1;
    #1;
    nchecks++;
    if ({dtack, avec, data_oe} !== 3'b000) begin
      nerrors++; $display("FAIL midreset_drop: got %b expected 000", {dtack, avec, data_oe});
    end
    as_i = 1'b0; uds = 1'b0; lds = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_reg(BASE + 24'd2);
    nchecks++;
    if (b_lat !== 2 || b_dt !== 1'b1 || b_rd !== 16'h0000) begin
      nerrors++;
      $display("FAIL midreset_after: lat %0d dtack %b data %h expected 2 1 0000", b_lat, b_dt, b_rd);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_iack();
    test_oneshot();
    test_byte_lanes();
    test_status_race();
    test_reset_midcycle();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
